// File: rtl/serv_immenc_pkg.sv
// Shared definitions for the serial immediate encoder: format codes, bench opcodes,
// FSM state type and the bundle of parallel instruction fields.
package serv_immenc_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } insn_fields_t;

endpackage

// File: rtl/serv_immenc_pack.sv
// Combinational RV32I word packer for one format, plus the immediate range check
// (compiled in only when SERV_IMMENC_RANGE_CHECK_EN is defined).
module serv_immenc_pack
   import serv_immenc_pkg::*;
(
   input  logic [2:0]   fmt,
   input  insn_fields_t fields,
   input  logic [31:0]  imm,
   output logic [31:0]  insn,
   output logic         err
);

   always_comb begin
      insn = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      case (fmt)
         FMT_I: insn = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
         FMT_S: insn = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
         FMT_B: insn = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        imm[4:1], imm[11], fields.opcode};
         FMT_U: insn = {imm[31:12], fields.rd, fields.opcode};
         FMT_J: insn = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
         default: ;
      endcase
   end

`ifdef SERV_IMMENC_RANGE_CHECK_EN
   // A field fits when all bits above it are copies of its sign bit.
   always_comb begin
      err = 1'b0;
      case (fmt)
         FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
         FMT_B:        err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
         FMT_U:        err = |imm[11:0];
         FMT_J:        err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
         default:      err = 1'b0;
      endcase
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/serv_immenc.sv
// Bit-serial immediate encoder: collects an LSB-first immediate W bits per beat and
// emits a packed RV32I word on a valid/ready handshake. Option: SERV_IMMENC_RANGE_CHECK_EN.
module serv_immenc
   import serv_immenc_pkg::*;
#(
   parameter int W = 1
)(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [2:0]   i_fmt,
   input  logic [6:0]   i_opcode,
   input  logic [2:0]   i_funct3,
   input  logic [6:0]   i_funct7,
   input  logic [4:0]   i_rd,
   input  logic [4:0]   i_rs1,
   input  logic [4:0]   i_rs2,
   input  logic         i_imm_valid,
   input  logic [W-1:0] i_imm,
   output logic         o_busy,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [31:0]  o_insn,
   output logic         o_err
);

   localparam int BEATS = 32 / W;
   localparam int CW    = (W == 1) ? 5 : 3;

   state_t         state, state_next;
   logic [CW-1:0]  cnt;
   logic [31-W:0]  sr;
   logic [2:0]     fmt_q;
   insn_fields_t   fields_q;
   insn_fields_t   fields_in;

   logic [31:0]    imm_full;
   logic           start_ok;
   logic           start_r;
   logic           last_beat;
   logic [2:0]     pack_fmt;
   insn_fields_t   pack_fields;
   logic [31:0]    pack_imm;
   logic [31:0]    pack_insn;
   logic           pack_err;

   // The register keeps only the bits seen so far; the final beat joins them directly.
   assign imm_full  = {i_imm, sr};
   assign fields_in = '{opcode: i_opcode, funct3: i_funct3, funct7: i_funct7,
                        rd: i_rd, rs1: i_rs1, rs2: i_rs2};
   assign start_ok  = (state == IDLE) && i_start;
   assign start_r   = (i_fmt == FMT_R) || (i_fmt > FMT_J);
   assign last_beat = (state == SHIFT) && i_imm_valid && (cnt == CW'(BEATS - 1));

   // R-type words are packed straight from the live inputs in the start cycle.
   always_comb begin
      pack_fmt    = fmt_q;
      pack_fields = fields_q;
      pack_imm    = imm_full;
      if (state == IDLE) begin
         pack_fmt    = FMT_R;
         pack_fields = fields_in;
         pack_imm    = '0;
      end
   end

   serv_immenc_pack u_pack (
      .fmt    (pack_fmt),
      .fields (pack_fields),
      .imm    (pack_imm),
      .insn   (pack_insn),
      .err    (pack_err)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_start) state_next = start_r ? DONE : SHIFT;
         SHIFT:   if (last_beat) state_next = DONE;
         DONE:    if (i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         sr       <= '0;
         fmt_q    <= FMT_R;
         fields_q <= '0;
         o_insn   <= '0;
         o_err    <= 1'b0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            cnt      <= '0;
            sr       <= '0;
            fmt_q    <= i_fmt;
            fields_q <= fields_in;
         end else if ((state == SHIFT) && i_imm_valid) begin
            cnt <= cnt + CW'(1);
            sr  <= imm_full[31:W];
         end
         if ((start_ok && start_r) || last_beat) begin
            o_insn <= pack_insn;
            o_err  <= pack_err;
         end
      end
   end

   assign o_valid = (state == DONE);
   assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_serv_immenc.sv
// Directed self-checking bench for serv_immenc: one W=1 and one W=4 instance driven
// from a vector table, plus backpressure and mid-encode reset sequences.
module tb_serv_immenc;
   import serv_immenc_pkg::*;

`ifdef SERV_IMMENC_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   typedef struct {
      bit          w4;
      bit          gaps;
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] expInsn;
      bit          expErr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start1, start4;
   logic [2:0]  fmt;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic        immValid;
   logic [0:0]  imm1;
   logic [3:0]  imm4;
   logic        ready;
   logic        busy1, valid1, err1, busy4, valid4, err4;
   logic [31:0] insn1, insn4;

   bit          sel4;
   logic        busyS, validS, errS;
   logic [31:0] insnS;

   int          tests = 0;
   int          fails = 0;
   vec_t        vecs[12];

   always #5 clk = ~clk;

   serv_immenc #(.W(1)) dut1 (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start1), .i_fmt(fmt), .i_opcode(opcode),
      .i_funct3(funct3), .i_funct7(funct7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
      .i_imm_valid(immValid), .i_imm(imm1), .o_busy(busy1), .o_valid(valid1),
      .i_ready(ready), .o_insn(insn1), .o_err(err1)
   );

   serv_immenc #(.W(4)) dut4 (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start4), .i_fmt(fmt), .i_opcode(opcode),
      .i_funct3(funct3), .i_funct7(funct7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
      .i_imm_valid(immValid), .i_imm(imm4), .o_busy(busy4), .o_valid(valid4),
      .i_ready(ready), .o_insn(insn4), .o_err(err4)
   );

   always_comb begin
      busyS  = sel4 ? busy4  : busy1;
      validS = sel4 ? valid4 : valid1;
      errS   = sel4 ? err4   : err1;
      insnS  = sel4 ? insn4  : insn1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts an encode and feeds every beat; returns one cycle after the final beat.
   task automatic runToDone(input vec_t v, input string name);
      int          beats;
      int          bw;
      logic [31:0] tmp;
      sel4   = v.w4;
      fmt    = v.fmt;
      opcode = v.op;
      funct3 = v.f3;
      funct7 = v.f7;
      rd     = v.rd;
      rs1    = v.rs1;
      rs2    = v.rs2;
      if (v.w4) start4 = 1'b1; else start1 = 1'b1;
      step();
      start1 = 1'b0;
      start4 = 1'b0;
      if (!(v.fmt == FMT_R || v.fmt > FMT_J)) begin
         bw    = v.w4 ? 4 : 1;
         beats = 32 / bw;
         for (int b = 0; b < beats; b++) begin
            if (v.gaps && (b % 2 == 1)) begin
               immValid = 1'b0;
               imm1     = 1'b1;
               imm4     = 4'hF;
               step();
               step();
               checkOutput({name, " stall"}, 32'(validS), 32'd0);
            end
            tmp      = v.imm >> (b * bw);
            imm1     = tmp[0:0];
            imm4     = tmp[3:0];
            immValid = 1'b1;
            step();
            immValid = 1'b0;
            if (b == beats - 2)
               checkOutput({name, " early"}, 32'(validS), 32'd0);
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string name);
      runToDone(v, name);
      checkOutput({name, " valid"}, 32'(validS), 32'd1);
      checkOutput({name, " insn"}, insnS, v.expInsn);
      checkOutput({name, " err"}, 32'(errS), 32'(RANGE_CHECK & v.expErr));
      ready = 1'b1;
      step();
      ready = 1'b0;
      checkOutput({name, " idle"}, {30'd0, busyS, validS}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                   32'h00000005, 32'h00500093, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2,
                   32'h00000008, 32'h0021A423, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                   32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
                   32'h12345000, 32'h123452B7, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                   32'h00000800, 32'h80000093, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                   32'h00000003, 32'h002000EF, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, FMT_R, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3,
                   32'h00000000, 32'h403100B3, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 3'd7, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3,
                   32'hDEADBEEF, 32'h403100B3, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                   32'hFFFFF800, 32'h801FF06F, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, FMT_U, OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                   32'h00001FFF, 32'h00001037, 1'b1};
      vecs[10] = '{1'b1, 1'b0, FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2,
                   32'hFFFFFFFF, 32'hFE20AFA3, 1'b0};
      vecs[11] = '{1'b0, 1'b0, FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                   32'h00000001, 32'h00000063, 1'b1};

      rstN = 1'b0; start1 = 1'b0; start4 = 1'b0; immValid = 1'b0; ready = 1'b0;
      imm1 = 1'b0; imm4 = 4'h0; fmt = FMT_R; opcode = 7'd0; funct3 = 3'd0;
      funct7 = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; sel4 = 1'b0;

      #12;
      checkOutput("reset w1 flags", {29'd0, busy1, valid1, err1}, 32'd0);
      checkOutput("reset w1 insn", insn1, 32'd0);
      checkOutput("reset w4 flags", {29'd0, busy4, valid4, err4}, 32'd0);
      checkOutput("reset w4 insn", insn4, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         step();
      end

      // Backpressure: the word must hold while ready is low and a stray start is ignored.
      runToDone(vecs[3], "bp");
      for (int c = 0; c < 5; c++) begin
         fmt    = FMT_R;
         funct7 = 7'h7F;
         start1 = (c == 2);
         step();
         start1 = 1'b0;
         checkOutput($sformatf("bp hold valid %0d", c), 32'(valid1), 32'd1);
         checkOutput($sformatf("bp hold insn %0d", c), insn1, 32'h123452B7);
      end
      start1 = 1'b1;
      ready  = 1'b1;
      step();
      start1 = 1'b0;
      ready  = 1'b0;
      checkOutput("bp handshake idle", {30'd0, busy1, valid1}, 32'd0);
      checkOutput("bp insn retained", insn1, 32'h123452B7);
      step();
      checkOutput("bp start ignored", 32'(busy1), 32'd0);

      // Reset part way through a W=1 encode, then a clean encode afterwards.
      sel4   = 1'b0;
      fmt    = FMT_I; opcode = OP_IMM; funct3 = 3'd0; rd = 5'd1; rs1 = 5'd0;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int b = 0; b < 10; b++) begin
         immValid = 1'b1;
         imm1     = 1'b1;
         step();
      end
      immValid = 1'b0;
      #3 rstN = 1'b0;
      #1;
      checkOutput("rst mid busy/valid", {30'd0, busy1, valid1}, 32'd0);
      checkOutput("rst mid insn", insn1, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      step();
      applyStimulus(vecs[0], "after rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
